// File: rtl/act_feed_sequencer.sv
// Row-0 read sequencer for the systolic array activation buffer: streams ROW_LEN
// reads per tile, waits out the skew drain plus GAP, and pulses done after the last tile.
module act_feed_sequencer #(
    parameter int SYS_ROWS = 4,
    parameter int ROW_LEN  = 8,
    parameter int GAP      = 2,
    parameter int TILE_W   = 8,
    parameter int ROW_W    = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              stall,
    output logic              read,
    output logic [ROW_W-1:0]  row_idx,
    output logic [TILE_W-1:0] tile_idx,
    output logic              last_row,
    output logic              busy,
    output logic              done
);

    localparam int D  = SYS_ROWS - 1 + GAP;
    localparam int DW = (D > 1) ? $clog2(D + 1) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_LEN - 1);
    localparam logic [DW-1:0]    D_LOAD   = DW'(D);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [DW-1:0]       drain_cnt;
    logic [TILE_W-1:0]   tiles_q;
    logic                tile_last;

    // read follows stall in the same cycle so the array never sees a read it refused
    assign read      = (state == FEED) && !stall;
    assign last_row  = read && (row_idx == ROW_LAST);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign tile_last = (tile_idx == (tiles_q - TILE_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row_idx   <= '0;
            tile_idx  <= '0;
            drain_cnt <= '0;
            tiles_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row_idx  <= '0;
                        tile_idx <= '0;
                        tiles_q  <= num_tiles;
                        state    <= (num_tiles != '0) ? FEED : DONE;
                    end
                end
                FEED: begin
                    if (!stall) begin
                        if (row_idx != ROW_LAST) begin
                            row_idx <= row_idx + ROW_W'(1);
                        end else begin
                            row_idx <= '0;
                            // with no drain time the next tile starts straight away
                            if (D == 0) begin
                                if (tile_last) begin
                                    state <= DONE;
                                end else begin
                                    tile_idx <= tile_idx + TILE_W'(1);
                                end
                            end else begin
                                drain_cnt <= D_LOAD;
                                state     <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt <= DW'(1)) begin
                        drain_cnt <= '0;
                        if (tile_last) begin
                            state <= DONE;
                        end else begin
                            tile_idx <= tile_idx + TILE_W'(1);
                            state    <= FEED;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
